// File: rtl/riscv_pkg.sv
// Shared RISC-V platform definitions: default word widths and the
// program-loader state encoding.
package riscv_pkg;

  localparam int unsigned XLenDefault = 32;
  localparam int unsigned ILenDefault = 32;

  typedef enum logic [2:0] {
    S_LEN   = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } loader_state_e;

endpackage

// File: rtl/pmem_loader.sv
// Streams a length-prefixed, checksummed program image into program memory
// and holds the core in reset until a complete, valid image has landed.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_LEN   | waiting for the header word (program length N)
//   S_LOAD  | writing program words, accumulating the running sum
//   S_CHECK | waiting for the checksum word
//   S_DONE  | image verified, core released from reset
//   S_ERROR | bad length or checksum, core held in reset until restart
module pmem_loader
  import riscv_pkg::*;
#(
  parameter int unsigned XLen      = XLenDefault,
  parameter int unsigned NPos      = 1024,
  parameter int unsigned AddrWidth = $clog2(NPos)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 s_valid_i,
  input  logic [XLen-1:0]      s_data_i,
  output logic                 s_ready_o,
  input  logic                 restart_i,
  output logic                 pmem_we_o,
  output logic [AddrWidth-1:0] pmem_addr_o,
  output logic [XLen-1:0]      pmem_wdata_o,
  output logic                 core_rst_no,
  output logic                 done_o,
  output logic                 error_o
);

  // Counter carries one extra bit so a full-depth image (N = NPos) is legal.
  localparam logic [XLen-1:0]    NPosW  = XLen'(NPos);
  localparam logic [AddrWidth:0] CntOne = (AddrWidth + 1)'(1);

  loader_state_e        state_q, state_d;
  logic [AddrWidth:0]   cnt_q, cnt_d;
  logic [AddrWidth:0]   len_q, len_d;
  logic [XLen-1:0]      sum_q, sum_d;
  logic                 we_q, we_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [XLen-1:0]      wdata_q, wdata_d;
  logic                 core_rst_q;
  logic                 beat;

  assign beat = s_valid_i & s_ready_o;

  // State, datapath and registered memory/core-reset outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_LEN;
      cnt_q      <= '0;
      len_q      <= '0;
      sum_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      sum_q      <= sum_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      core_rst_q <= (state_d == S_DONE);
    end
  end

  // Next-state and datapath update; restart overrides any concurrent beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (restart_i) begin
      state_d = S_LEN;
      cnt_d   = '0;
      sum_d   = '0;
    end else if (beat) begin
      unique case (state_q)
        S_LEN: begin
          cnt_d = '0;
          sum_d = '0;
          if (s_data_i > NPosW) begin
            state_d = S_ERROR;
          end else if (s_data_i == '0) begin
            state_d = S_CHECK;
          end else begin
            len_d   = s_data_i[AddrWidth:0];
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          sum_d   = sum_q + s_data_i;
          cnt_d   = cnt_q + CntOne;
          we_d    = 1'b1;
          addr_d  = cnt_q[AddrWidth-1:0];
          wdata_d = s_data_i;
          if (cnt_q + CntOne == len_q) state_d = S_CHECK;
        end
        S_CHECK: state_d = (s_data_i == sum_q) ? S_DONE : S_ERROR;
        default: state_d = state_q;
      endcase
    end
  end

  // Handshake and status decoded directly from the current state.
  always_comb begin
    s_ready_o = 1'b0;
    done_o    = 1'b0;
    error_o   = 1'b0;
    unique case (state_q)
      S_LEN, S_LOAD, S_CHECK: s_ready_o = 1'b1;
      S_DONE:                 done_o    = 1'b1;
      S_ERROR:                error_o   = 1'b1;
      default:                s_ready_o = 1'b0;
    endcase
  end

  assign pmem_we_o    = we_q;
  assign pmem_addr_o  = addr_q;
  assign pmem_wdata_o = wdata_q;
  assign core_rst_no  = core_rst_q;

endmodule
